// File: rtl/issue_queue_param.sv
// Age-ordered collapsing issue queue: index 0 is the oldest entry, sources wake on
// writeback tag broadcasts, and one ready entry issues per cycle (oldest-ready or head-only).
module issue_queue_param #(
    parameter int DEPTH      = 8,
    parameter int OPC_W      = 6,
    parameter int IMM_W      = 32,
    parameter int REG_W      = 5,
    parameter int NUM_WB     = 2,
    parameter int ISSUE_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [OPC_W-1:0]          disp_opcode,
    input  logic [IMM_W-1:0]          disp_imm,
    input  logic [REG_W-1:0]          disp_dest,
    input  logic                      disp_dest_v,
    input  logic [REG_W-1:0]          disp_src1,
    input  logic [REG_W-1:0]          disp_src2,
    input  logic                      disp_src1_v,
    input  logic                      disp_src2_v,
    input  logic                      disp_src1_p,
    input  logic                      disp_src2_p,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*REG_W-1:0]   wb_tag,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [OPC_W-1:0]          issue_opcode,
    output logic [IMM_W-1:0]          issue_imm,
    output logic [REG_W-1:0]          issue_dest,
    output logic                      issue_dest_v,
    output logic [REG_W-1:0]          issue_src1,
    output logic [REG_W-1:0]          issue_src2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] dest;
        logic             dest_v;
        logic [REG_W-1:0] src1;
        logic             src1_v;
        logic             src1_p;
        logic [REG_W-1:0] src2;
        logic             src2_v;
        logic             src2_p;
    } entry_t;

    entry_t          ent_q   [DEPTH];
    entry_t          ent_d   [DEPTH];
    entry_t          ent_ext [DEPTH+1];
    entry_t          new_ent;
    entry_t          sel_ent;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [DEPTH-1:0] rdy;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   wr_idx;
    logic            disp_fire;
    logic            iss_fire;

    function automatic logic wb_hit(input logic [REG_W-1:0]        r,
                                    input logic [NUM_WB-1:0]       wv,
                                    input logic [NUM_WB*REG_W-1:0] wt);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wv[i] && (wt[i*REG_W +: REG_W] == r)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic entry_t apply_wake(input entry_t                  e,
                                          input logic [NUM_WB-1:0]       wv,
                                          input logic [NUM_WB*REG_W-1:0] wt);
        entry_t r;
        r = e;
        r.src1_p = e.src1_p & ~(e.src1_v & wb_hit(e.src1, wv, wt));
        r.src2_p = e.src2_p & ~(e.src2_v & wb_hit(e.src2, wv, wt));
        return r;
    endfunction

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign disp_ready = !full;
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_fire   = sel_found && issue_ready;

    // Readiness uses registered pending bits only, so a wakeup becomes issuable next cycle.
    always_comb begin
        rdy = '0;
        for (int j = 0; j < DEPTH; j++) begin
            rdy[j] = (CW'(j) < count_q)
                   && (!ent_q[j].src1_v || !ent_q[j].src1_p)
                   && (!ent_q[j].src2_v || !ent_q[j].src2_p);
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (ISSUE_MODE == 1) begin
            sel_found = rdy[0];
        end else begin
            for (int j = DEPTH-1; j >= 0; j--) begin
                if (rdy[j]) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(j);
                end
            end
        end
    end

    assign sel_ent      = sel_found ? ent_q[sel_idx] : '0;
    assign issue_valid  = sel_found;
    assign issue_opcode = sel_ent.opcode;
    assign issue_imm    = sel_ent.imm;
    assign issue_dest   = sel_ent.dest;
    assign issue_dest_v = sel_ent.dest_v;
    assign issue_src1   = sel_ent.src1;
    assign issue_src2   = sel_ent.src2;

    always_comb begin
        new_ent        = '0;
        new_ent.opcode = disp_opcode;
        new_ent.imm    = disp_imm;
        new_ent.dest   = disp_dest;
        new_ent.dest_v = disp_dest_v;
        new_ent.src1   = disp_src1;
        new_ent.src1_v = disp_src1_v;
        new_ent.src2   = disp_src2;
        new_ent.src2_v = disp_src2_v;
        new_ent.src1_p = disp_src1_p && (disp_src1 != '0)
                      && !(disp_src1_v && wb_hit(disp_src1, wb_valid, wb_tag));
        new_ent.src2_p = disp_src2_p && (disp_src2 != '0)
                      && !(disp_src2_v && wb_hit(disp_src2, wb_valid, wb_tag));
    end

    // Collapse above the issued slot, wake everything, then append the dispatch at the new tail.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) ent_ext[j] = ent_q[j];
        ent_ext[DEPTH] = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (iss_fire && (IW'(j) >= sel_idx)) begin
                ent_d[j] = apply_wake(ent_ext[j+1], wb_valid, wb_tag);
            end else begin
                ent_d[j] = apply_wake(ent_ext[j], wb_valid, wb_tag);
            end
        end
        wr_idx = IW'(count_q - CW'(iss_fire));
        if (disp_fire) ent_d[wr_idx] = new_ent;
        count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
        if (flush) count_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) ent_q[j] <= '0;
        end else begin
            count_q <= count_d;
            for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
        end
    end

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param: two instances (out-of-order and in-order), with a
// scoreboard of expected issue destinations popped by a monitor on every issue handshake.
module tb_issue_queue_param;

    logic clk = 1'b0;
    logic rst;

    logic       flush       [2];
    logic       disp_valid  [2];
    logic       disp_ready  [2];
    logic [5:0] disp_opcode [2];
    logic [31:0] disp_imm   [2];
    logic [4:0] disp_dest   [2];
    logic       disp_dest_v [2];
    logic [4:0] disp_src1   [2];
    logic [4:0] disp_src2   [2];
    logic       disp_src1_v [2];
    logic       disp_src2_v [2];
    logic       disp_src1_p [2];
    logic       disp_src2_p [2];
    logic [1:0] wb_valid    [2];
    logic [9:0] wb_tag      [2];
    logic       issue_valid [2];
    logic       issue_ready [2];
    logic [5:0] issue_opcode[2];
    logic [31:0] issue_imm  [2];
    logic [4:0] issue_dest  [2];
    logic       issue_dest_v[2];
    logic [4:0] issue_src1  [2];
    logic [4:0] issue_src2  [2];
    logic [3:0] count       [2];
    logic       full        [2];
    logic       empty       [2];

    logic [4:0] exp0[$];
    logic [4:0] exp1[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        issue_queue_param #(
            .DEPTH(8), .OPC_W(6), .IMM_W(32), .REG_W(5), .NUM_WB(2), .ISSUE_MODE(g)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush[g]),
            .disp_valid(disp_valid[g]), .disp_ready(disp_ready[g]),
            .disp_opcode(disp_opcode[g]), .disp_imm(disp_imm[g]),
            .disp_dest(disp_dest[g]), .disp_dest_v(disp_dest_v[g]),
            .disp_src1(disp_src1[g]), .disp_src2(disp_src2[g]),
            .disp_src1_v(disp_src1_v[g]), .disp_src2_v(disp_src2_v[g]),
            .disp_src1_p(disp_src1_p[g]), .disp_src2_p(disp_src2_p[g]),
            .wb_valid(wb_valid[g]), .wb_tag(wb_tag[g]),
            .issue_valid(issue_valid[g]), .issue_ready(issue_ready[g]),
            .issue_opcode(issue_opcode[g]), .issue_imm(issue_imm[g]),
            .issue_dest(issue_dest[g]), .issue_dest_v(issue_dest_v[g]),
            .issue_src1(issue_src1[g]), .issue_src2(issue_src2[g]),
            .count(count[g]), .full(full[g]), .empty(empty[g])
        );
    end

    // Every op carries opcode/imm derived from its dest so the monitor can check all payload fields.
    always @(negedge clk) begin
        if (!rst) begin
            for (int w = 0; w < 2; w++) begin
                if (issue_valid[w] && issue_ready[w]) begin
                    logic [4:0] e;
                    bit         have;
                    have = 1'b0;
                    e    = '0;
                    if (w == 0 && exp0.size() != 0) begin
                        e = exp0.pop_front(); have = 1'b1;
                    end else if (w == 1 && exp1.size() != 0) begin
                        e = exp1.pop_front(); have = 1'b1;
                    end
                    total++;
                    if (!have) begin
                        bad++;
                        $display("[TB] FAIL issue%0d_unexpected: got dest=%0d, required no issue", w, issue_dest[w]);
                    end else if ({issue_opcode[w], issue_imm[w], issue_dest[w], issue_dest_v[w]} !==
                                 {1'b0, e, 32'hA000_0000 | {27'd0, e}, e, 1'b1}) begin
                        bad++;
                        $display("[TB] FAIL issue%0d_order: got dest=%0d opc=%0d imm=%h, required dest=%0d",
                                 w, issue_dest[w], issue_opcode[w], issue_imm[w], e);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int w, input logic dv, input logic [4:0] dest,
                                 input logic [4:0] s1, input logic v1, input logic p1,
                                 input logic [4:0] s2, input logic v2, input logic p2,
                                 input logic ir, input logic [1:0] wv,
                                 input logic [4:0] t0, input logic [4:0] t1, input logic fl);
        for (int i = 0; i < 2; i++) begin
            disp_valid[i]  = 1'b0;
            issue_ready[i] = 1'b0;
            flush[i]       = 1'b0;
            wb_valid[i]    = 2'b00;
        end
        disp_valid[w]  = dv;
        disp_opcode[w] = {1'b0, dest};
        disp_imm[w]    = 32'hA000_0000 | {27'd0, dest};
        disp_dest[w]   = dest;
        disp_dest_v[w] = 1'b1;
        disp_src1[w]   = s1;
        disp_src1_v[w] = v1;
        disp_src1_p[w] = p1;
        disp_src2[w]   = s2;
        disp_src2_v[w] = v2;
        disp_src2_p[w] = p2;
        issue_ready[w] = ir;
        wb_valid[w]    = wv;
        wb_tag[w]      = {t1, t0};
        flush[w]       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int w, input logic [4:0] dest,
                            input logic [4:0] s1, input logic v1, input logic p1,
                            input logic [4:0] s2, input logic v2, input logic p2, input logic ir);
        applyStimulus(w, 1'b1, dest, s1, v1, p1, s2, v2, p2, ir, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic idle(input int w, input logic ir);
        applyStimulus(w, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ir, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic wake(input int w, input logic [1:0] wv, input logic [4:0] t0,
                        input logic [4:0] t1, input logic ir);
        applyStimulus(w, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ir, wv, t0, t1, 1'b0);
    endtask

    task automatic checkReset(input int w, input string tag);
        checkOutput({tag, "_count"}, 32'(count[w]), 0);
        checkOutput({tag, "_empty"}, 32'(empty[w]), 1);
        checkOutput({tag, "_full"}, 32'(full[w]), 0);
        checkOutput({tag, "_disp_ready"}, 32'(disp_ready[w]), 1);
        checkOutput({tag, "_issue_valid"}, 32'(issue_valid[w]), 0);
        checkOutput({tag, "_issue_dest"}, 32'(issue_dest[w]), 0);
        checkOutput({tag, "_issue_imm"}, issue_imm[w], 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush[i] = 0; disp_valid[i] = 0; disp_opcode[i] = 0; disp_imm[i] = 0;
            disp_dest[i] = 0; disp_dest_v[i] = 0; disp_src1[i] = 0; disp_src2[i] = 0;
            disp_src1_v[i] = 0; disp_src2_v[i] = 0; disp_src1_p[i] = 0; disp_src2_p[i] = 0;
            wb_valid[i] = 0; wb_tag[i] = 0; issue_ready[i] = 0;
        end
        idle(0, 1'b0);
        idle(0, 1'b0);
        checkReset(0, "rst0");
        checkReset(1, "rst1");
        rst = 1'b0;

        // Fill to full, then drain in age order; a dispatch while full is refused even as one issues.
        for (int d = 1; d <= 8; d++) dispatch(0, 5'(d), 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("fill_count", 32'(count[0]), 8);
        checkOutput("fill_full", 32'(full[0]), 1);
        checkOutput("fill_disp_ready", 32'(disp_ready[0]), 0);
        checkOutput("fill_head", 32'(issue_dest[0]), 1);
        for (int d = 1; d <= 8; d++) exp0.push_back(5'(d));
        dispatch(0, 5'd9, 0, 0, 0, 0, 0, 0, 1'b1);
        checkOutput("full_no_passthru_count", 32'(count[0]), 7);
        repeat (7) idle(0, 1'b1);
        checkOutput("drain_empty", 32'(empty[0]), 1);
        checkOutput("drain_issue_valid", 32'(issue_valid[0]), 0);

        // Out-of-order: younger ready B passes older pending A.
        dispatch(0, 5'd10, 5'd3, 1, 1, 0, 0, 0, 1'b0);
        dispatch(0, 5'd11, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("ooo_sel_b", 32'(issue_dest[0]), 11);
        exp0.push_back(5'd11);
        idle(0, 1'b1);
        checkOutput("ooo_a_waits", 32'(issue_valid[0]), 0);
        wake(0, 2'b01, 5'd3, 5'd0, 1'b1);
        checkOutput("ooo_a_woken", 32'(issue_dest[0]), 10);
        exp0.push_back(5'd10);
        idle(0, 1'b1);
        checkOutput("ooo_empty", 32'(empty[0]), 1);

        // In-order instance: head A blocks B until it wakes.
        dispatch(1, 5'd10, 5'd3, 1, 1, 0, 0, 0, 1'b0);
        dispatch(1, 5'd11, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("ino_blocked", 32'(issue_valid[1]), 0);
        checkOutput("ino_count", 32'(count[1]), 2);
        idle(1, 1'b1);
        checkOutput("ino_still_blocked", 32'(issue_valid[1]), 0);
        wake(1, 2'b01, 5'd3, 5'd0, 1'b1);
        checkOutput("ino_head_a", 32'(issue_dest[1]), 10);
        exp1.push_back(5'd10);
        exp1.push_back(5'd11);
        idle(1, 1'b1);
        checkOutput("ino_head_b", 32'(issue_dest[1]), 11);
        idle(1, 1'b1);
        checkOutput("ino_empty", 32'(empty[1]), 1);

        // Wakeup on port 1 during dispatch, non-matching tag stays pending, src 0 never pending.
        applyStimulus(0, 1'b1, 5'd13, 0, 0, 0, 5'd9, 1, 1, 1'b0, 2'b10, 5'd0, 5'd7, 1'b0);
        checkOutput("nomatch_pending", 32'(issue_valid[0]), 0);
        applyStimulus(0, 1'b1, 5'd12, 0, 0, 0, 5'd7, 1, 1, 1'b0, 2'b10, 5'd0, 5'd7, 1'b0);
        checkOutput("disp_wake_p1", 32'(issue_dest[0]), 12);
        exp0.push_back(5'd12);
        idle(0, 1'b1);
        dispatch(0, 5'd14, 5'd0, 1, 1, 0, 0, 0, 1'b0);
        checkOutput("src0_not_pending", 32'(issue_dest[0]), 14);
        exp0.push_back(5'd14);
        idle(0, 1'b1);
        wake(0, 2'b01, 5'd9, 5'd0, 1'b0);
        checkOutput("wake_p0_src2", 32'(issue_dest[0]), 13);
        exp0.push_back(5'd13);
        idle(0, 1'b1);
        checkOutput("wake_empty", 32'(empty[0]), 1);

        // Issue from the middle while dispatching; shifted entries keep and gain wakeups.
        dispatch(0, 5'd16, 5'd5, 1, 1, 0, 0, 0, 1'b0);
        dispatch(0, 5'd17, 0, 0, 0, 0, 0, 0, 1'b0);
        dispatch(0, 5'd18, 0, 0, 0, 0, 0, 0, 1'b0);
        dispatch(0, 5'd19, 5'd6, 1, 1, 0, 0, 0, 1'b0);
        checkOutput("mid_count4", 32'(count[0]), 4);
        checkOutput("mid_sel1", 32'(issue_dest[0]), 17);
        exp0.push_back(5'd17);
        dispatch(0, 5'd20, 0, 0, 0, 0, 0, 0, 1'b1);
        checkOutput("mid_count_kept", 32'(count[0]), 4);
        checkOutput("mid_shift_2to1", 32'(issue_dest[0]), 18);
        exp0.push_back(5'd18);
        wake(0, 2'b10, 5'd0, 5'd6, 1'b1);
        checkOutput("mid_shift_wake", 32'(issue_dest[0]), 19);
        checkOutput("mid_count3", 32'(count[0]), 3);
        exp0.push_back(5'd19);
        idle(0, 1'b1);
        checkOutput("mid_new_tail", 32'(issue_dest[0]), 20);
        exp0.push_back(5'd20);
        idle(0, 1'b1);
        checkOutput("mid_head_pending", 32'(issue_valid[0]), 0);
        wake(0, 2'b01, 5'd5, 5'd0, 1'b0);
        checkOutput("mid_head_woken", 32'(issue_dest[0]), 16);
        exp0.push_back(5'd16);
        idle(0, 1'b1);
        checkOutput("mid_empty", 32'(empty[0]), 1);

        // Flush beats same-cycle dispatch; the issue handshake in that cycle still completes.
        for (int d = 21; d <= 25; d++) dispatch(0, 5'(d), 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("flush_pre_count", 32'(count[0]), 5);
        exp0.push_back(5'd21);
        applyStimulus(0, 1'b1, 5'd26, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b1);
        checkOutput("flush_count", 32'(count[0]), 0);
        checkOutput("flush_issue_valid", 32'(issue_valid[0]), 0);
        idle(0, 1'b1);
        checkOutput("flush_discard", 32'(empty[0]), 1);

        // Asynchronous reset in the middle of a fill clears outputs before any clock edge.
        for (int d = 27; d <= 29; d++) dispatch(0, 5'(d), 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("midrst_pre_count", 32'(count[0]), 3);
        rst = 1'b1;
        #2;
        checkReset(0, "midrst");
        rst = 1'b0;
        dispatch(0, 5'd30, 0, 0, 0, 0, 0, 0, 1'b0);
        checkOutput("post_rst_accept", 32'(count[0]), 1);
        exp0.push_back(5'd30);
        idle(0, 1'b1);
        checkOutput("post_rst_empty", 32'(empty[0]), 1);

        idle(0, 1'b0);
        idle(0, 1'b0);
        checkOutput("sb0_drained", 32'(exp0.size()), 0);
        checkOutput("sb1_drained", 32'(exp1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
